pes_udc: RTL and testbench

//  Parametrised up/down counter; successor to the fixed 4-bit binary up counter.

---
 rtl/pes_udc_if.sv | 30 +++
 rtl/pes_udc.sv | 83 ++++++++
 tb/tb_pes_udc.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pes_udc_if.sv
// pes_udc control/status bundle.
// Master drives controls; slave returns count and flags.
interface pes_udc_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic             Up_dn;
  logic             Sat_mode;
  logic             Load;
  logic [WIDTH-1:0] Load_val;
  logic             Clr_ovf;
  logic [WIDTH-1:0] Count_out;
  logic             Tc;
  logic             Wrap_pulse;
  logic             Ovf;

  modport master (
    output Enable, Up_dn, Sat_mode,
    output Load, Load_val, Clr_ovf,
    input  Count_out, Tc,
    input  Wrap_pulse, Ovf
  );

  modport slave (
    input  Enable, Up_dn, Sat_mode,
    input  Load, Load_val, Clr_ovf,
    output Count_out, Tc,
    output Wrap_pulse, Ovf
  );
endinterface

// File: rtl/pes_udc.sv
// pes_udc: parametrised modulo up/down counter.
// Wrap or saturate at limits, sticky overflow, comb Tc.
module pes_udc #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input logic   Clock,
  input logic   Reset,
  pes_udc_if.slave bus
);
  localparam logic [WIDTH:0] MOD_W =
    (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_N =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_N =
    WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  logic             ovf_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   lv_x;
  logic             at_max;
  logic             at_zero;
  logic             wrap_ev;
  logic             ovf_ev;

  assign lv_x    = {1'b0, bus.Load_val};
  assign at_max  = (cnt_q == MAX_N);
  assign at_zero = (cnt_q == '0);

  // Next count and limit events; load beats step.
  always_comb begin
    nxt     = cnt_q;
    wrap_ev = 1'b0;
    ovf_ev  = 1'b0;
    if (bus.Load) begin
      nxt = (lv_x < MOD_W) ? bus.Load_val : MAX_N;
    end else if (bus.Enable) begin
      if (bus.Up_dn) begin
        if (at_max) begin
          ovf_ev = 1'b1;
          if (!bus.Sat_mode) begin
            nxt     = '0;
            wrap_ev = 1'b1;
          end
        end else begin
          nxt = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_ev = 1'b1;
          if (!bus.Sat_mode) begin
            nxt     = MAX_N;
            wrap_ev = 1'b1;
          end
        end else begin
          nxt = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Count, wrap pulse and sticky overflow registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q  <= RST_N;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= nxt;
      wrap_q <= wrap_ev;
      ovf_q  <= ovf_ev | (ovf_q & ~bus.Clr_ovf);
    end
  end

  assign bus.Count_out  = cnt_q;
  assign bus.Wrap_pulse = wrap_q;
  assign bus.Ovf        = ovf_q;
  assign bus.Tc = bus.Enable &
    ((bus.Up_dn & at_max) | (~bus.Up_dn & at_zero));
endmodule

// File: tb/tb_pes_udc.sv
// tb_pes_udc: directed and random checks of pes_udc.
// Two instances: (4,10,0) and (4,16,5) share stimulus.
module tb_pes_udc;
  logic Clock = 1'b0;
  logic Reset = 1'b1;

  pes_udc_if #(.WIDTH(4)) b0 ();
  pes_udc_if #(.WIDTH(4)) b1 ();

  pes_udc #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0))
    dut0 (.Clock(Clock), .Reset(Reset), .bus(b0));
  pes_udc #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5))
    dut1 (.Clock(Clock), .Reset(Reset), .bus(b1));

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  bit       en, up, sat, ld, clr;
  bit [3:0] lv;

  int m_mod [2] = '{10, 16};
  int m_rv  [2] = '{0, 5};
  int m_cnt [2];
  bit m_wp  [2];
  bit m_ovf [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] obs_of(input int k);
    if (k == 0)
      return {b0.Count_out, b0.Tc, b0.Wrap_pulse, b0.Ovf};
    return {b1.Count_out, b1.Tc, b1.Wrap_pulse, b1.Ovf};
  endfunction

  // Behavioural model of one rising edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  m = m_mod[k];
      bit  set = 0;
      if (Reset) begin
        m_cnt[k] = m_rv[k];
        m_wp[k]  = 0;
        m_ovf[k] = 0;
      end else begin
        m_wp[k] = 0;
        if (ld) begin
          m_cnt[k] = (int'(lv) < m) ? int'(lv) : m - 1;
        end else if (en && up) begin
          if (m_cnt[k] == m - 1) begin
            set = 1;
            if (!sat) begin
              m_cnt[k] = 0;
              m_wp[k]  = 1;
            end
          end else m_cnt[k]++;
        end else if (en) begin
          if (m_cnt[k] == 0) begin
            set = 1;
            if (!sat) begin
              m_cnt[k] = m - 1;
              m_wp[k]  = 1;
            end
          end else m_cnt[k]--;
        end
        if (set) m_ovf[k] = 1;
        else if (clr) m_ovf[k] = 0;
      end
    end
  endtask

  // Drive inputs, check Tc, clock once, check state.
  task automatic cyc();
    logic [6:0] o;
    b0.Enable = en;  b1.Enable = en;
    b0.Up_dn = up;   b1.Up_dn = up;
    b0.Sat_mode = sat; b1.Sat_mode = sat;
    b0.Load = ld;    b1.Load = ld;
    b0.Load_val = lv; b1.Load_val = lv;
    b0.Clr_ovf = clr; b1.Clr_ovf = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit tc;
      tc = en && ((up && m_cnt[k] == m_mod[k] - 1) ||
                  (!up && m_cnt[k] == 0));
      o = obs_of(k);
      chk($sformatf("tc%0d", k), 32'(o[2]), 32'(tc));
    end
    @(posedge Clock);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      o = obs_of(k);
      chk($sformatf("cnt%0d", k), 32'(o[6:3]),
          32'(m_cnt[k]));
      chk($sformatf("wp%0d", k), 32'(o[1]), 32'(m_wp[k]));
      chk($sformatf("ovf%0d", k), 32'(o[0]), 32'(m_ovf[k]));
    end
  endtask

  task automatic idle();
    en = 0; ld = 0; clr = 0;
  endtask

  initial begin
    idle(); up = 1; sat = 0; lv = 0;
    m_cnt = '{0, 0}; m_wp = '{0, 0}; m_ovf = '{0, 0};
    // Test 1: reset then wrap count up.
    Reset = 1;
    repeat (2) cyc();
    chk("rst_cnt0", 32'(b0.Count_out), 32'd0);
    chk("rst_cnt1", 32'(b1.Count_out), 32'd5);
    chk("rst_ovf0", 32'(b0.Ovf), 32'd0);
    Reset = 0;
    en = 1; up = 1; sat = 0;
    repeat (12) cyc();
    chk("t1_cnt", 32'(b0.Count_out), 32'd2);
    chk("t1_ovf", 32'(b0.Ovf), 32'd1);
    // Test 2: load 3, saturating down count.
    idle(); ld = 1; lv = 3; cyc();
    chk("t2_load", 32'(b0.Count_out), 32'd3);
    ld = 0; en = 1; up = 0; sat = 1;
    repeat (5) cyc();
    chk("t2_hold", 32'(b0.Count_out), 32'd0);
    chk("t2_wp", 32'(b0.Wrap_pulse), 32'd0);
    // Test 3: clamp load, load beats enable.
    idle(); ld = 1; lv = 14; cyc();
    chk("t3_clamp", 32'(b0.Count_out), 32'd9);
    en = 1; up = 0; ld = 1; lv = 4; cyc();
    chk("t3_prio", 32'(b0.Count_out), 32'd4);
    // Test 4: clear overflow, then clear during wrap.
    idle(); clr = 1; cyc();
    chk("t4_clr", 32'(b0.Ovf), 32'd0);
    idle(); ld = 1; lv = 9; cyc();
    idle(); en = 1; up = 1; sat = 0; clr = 1; cyc();
    chk("t4_setwin", 32'(b0.Ovf), 32'd1);
    chk("t4_wrap", 32'(b0.Count_out), 32'd0);
    // Test 5: reset mid-count with enable and load.
    idle(); ld = 1; lv = 6; cyc();
    en = 1; ld = 1; lv = 2; Reset = 1; cyc();
    Reset = 0;
    chk("t5_cnt0", 32'(b0.Count_out), 32'd0);
    chk("t5_cnt1", 32'(b1.Count_out), 32'd5);
    // Test 6: binary rollover and toggling direction.
    idle(); ld = 1; lv = 15; cyc();
    idle(); en = 1; up = 1; sat = 0; cyc();
    chk("t6_up", 32'(b1.Count_out), 32'd0);
    chk("t6_upwp", 32'(b1.Wrap_pulse), 32'd1);
    up = 0; cyc();
    chk("t6_dn", 32'(b1.Count_out), 32'd15);
    for (int i = 0; i < 8; i++) begin
      up = ~up; cyc();
    end
    // Random phase.
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom % 40) == 0;
      en  = ($urandom % 4) != 0;
      up  = $urandom % 2;
      sat = $urandom % 2;
      ld  = ($urandom % 8) == 0;
      lv  = 4'($urandom);
      clr = ($urandom % 6) == 0;
      cyc();
    end
    Reset = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
